i2s_dac_tx: RTL and testbench

//  Output end of the effects chain: takes the parallel stereo sample pair produced by an effect

---
 rtl/i2s_dac_tx.sv | 115 +++++++++++
 tb/tb_i2s_dac_tx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_dac_tx.sv
// I2S slave transmitter: resamples the codec's bclk/daclrck on CLK and shifts a held stereo pair
// out MSB-first. A one-deep holding register decouples the producer strobe from frame timing.
module i2s_dac_tx #(
  parameter int DATA_WIDTH  = 32,
  parameter int SLOT_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         CLK,
  input  logic                         rst,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] x_left,
  input  logic signed [DATA_WIDTH-1:0] x_right,
  input  logic                         audio_ready,
  input  logic                         clr_status,
  input  logic                         bclk,
  input  logic                         daclrck,
  output logic                         dacdat,
  output logic                         sample_taken,
  output logic [1:0]                   status
);

  localparam int CW = $clog2(SLOT_WIDTH + 1);
  localparam logic [CW-1:0] DW_C = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] SW_C = CW'(SLOT_WIDTH);

  logic [SYNC_STAGES-1:0]        bclk_sync_q, lrck_sync_q;
  logic                          bclk_dly_q, lrck_prev_q;
  logic signed [DATA_WIDTH-1:0]  hold_l_q, hold_r_q, frame_l_q, frame_r_q;
  logic                          hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0]         shift_q, shift_d;
  logic [CW-1:0]                 bit_cnt_q, bit_cnt_d;
  logic                          dacdat_q, dacdat_d;
  logic                          taken_q;
  logic [1:0]                    status_q, status_d;

  logic bclk_s, lrck_s, bclk_rise, bclk_fall;
  logic left_bnd, right_bnd, transfer, underrun, overrun;

  assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
  assign lrck_s    = lrck_sync_q[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_dly_q;
  assign bclk_fall = ~bclk_s & bclk_dly_q;
  assign left_bnd  = bclk_rise & (lrck_s != lrck_prev_q) & ~lrck_s;
  assign right_bnd = bclk_rise & (lrck_s != lrck_prev_q) & lrck_s;
  assign transfer  = left_bnd & en & hold_valid_q;
  assign underrun  = left_bnd & en & ~hold_valid_q;
  // A strobe landing on the transfer cycle refills the just-emptied holding register: not an overrun.
  assign overrun   = audio_ready & hold_valid_q & en & ~transfer;

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    dacdat_d  = dacdat_q;
    if (left_bnd) begin
      shift_d   = !en ? '0 : (transfer ? hold_l_q : frame_l_q);
      bit_cnt_d = '0;
    end else if (right_bnd) begin
      shift_d   = en ? frame_r_q : '0;
      bit_cnt_d = '0;
    end else if (bclk_fall) begin
      if (bit_cnt_q < DW_C) begin
        dacdat_d = shift_q[DATA_WIDTH-1];
        shift_d  = shift_q << 1;
      end else begin
        dacdat_d = 1'b0;
      end
      if (bit_cnt_q < SW_C) bit_cnt_d = bit_cnt_q + 1'b1;
    end
    hold_valid_d = audio_ready | (hold_valid_q & ~transfer);
    status_d     = (clr_status ? 2'b00 : status_q) | {overrun, underrun};
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      bclk_sync_q  <= '0;
      lrck_sync_q  <= '1;
      bclk_dly_q   <= 1'b0;
      lrck_prev_q  <= 1'b1;
      hold_l_q     <= '0;
      hold_r_q     <= '0;
      frame_l_q    <= '0;
      frame_r_q    <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      dacdat_q     <= 1'b0;
      taken_q      <= 1'b0;
      status_q     <= 2'b00;
    end else begin
      bclk_sync_q  <= {bclk_sync_q[SYNC_STAGES-2:0], bclk};
      lrck_sync_q  <= {lrck_sync_q[SYNC_STAGES-2:0], daclrck};
      bclk_dly_q   <= bclk_s;
      if (bclk_rise) lrck_prev_q <= lrck_s;
      if (audio_ready) begin
        hold_l_q <= x_left;
        hold_r_q <= x_right;
      end
      if (transfer) begin
        frame_l_q <= hold_l_q;
        frame_r_q <= hold_r_q;
      end
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      dacdat_q     <= dacdat_d;
      taken_q      <= transfer;
      status_q     <= status_d;
    end
  end

  assign dacdat       = dacdat_q;
  assign sample_taken = taken_q;
  assign status       = status_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: plays codec master (bclk = CLK/8, 64 bclk/frame) and compares each
// received slot word, sample_taken count and status against a transaction-level model.
module tb_i2s_dac_tx;
  localparam int SYNC = 2;

  logic CLK = 1'b0, rst = 1'b0, en = 1'b1, audio_ready = 1'b0, clr_status = 1'b0;
  logic bclk = 1'b1, daclrck = 1'b1;
  logic signed [31:0] x_left = '0, x_right = '0;
  logic dacdat, sample_taken;
  logic [1:0] status;

  int n_vec = 0, n_bad = 0, taken_cnt = 0;

  // model: one pending pair, the pair currently repeated each frame, sticky flags
  logic [31:0] pend_l = '0, pend_r = '0, frm_l = '0, frm_r = '0;
  bit          pend_v = 1'b0;
  logic [1:0]  st_m = 2'b00;

  // receiver state: bits of the slot being collected and its expected value
  logic [31:0] acc = '0, exp_w = '0;
  bit          have_slot = 1'b0;
  string       slot_tag = "";

  i2s_dac_tx #(.DATA_WIDTH(32), .SLOT_WIDTH(32), .SYNC_STAGES(SYNC)) dut (
    .CLK(CLK), .rst(rst), .en(en), .x_left(x_left), .x_right(x_right),
    .audio_ready(audio_ready), .clr_status(clr_status), .bclk(bclk), .daclrck(daclrck),
    .dacdat(dacdat), .sample_taken(sample_taken), .status(status)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (sample_taken === 1'b1) taken_cnt <= taken_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_strobe(input logic [31:0] l, input logic [31:0] r);
    if (pend_v && en) st_m[1] = 1'b1;
    pend_l = l; pend_r = r; pend_v = 1'b1;
  endtask

  task automatic strobe(input logic [31:0] l, input logic [31:0] r);
    x_left = l; x_right = r; audio_ready = 1'b1;
    @(negedge CLK);
    audio_ready = 1'b0;
    model_strobe(l, r);
  endtask

  task automatic clr();
    clr_status = 1'b1;
    @(negedge CLK);
    clr_status = 1'b0;
    st_m = 2'b00;
    @(negedge CLK);
    chk("clr_status", status, st_m);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_dacdat", dacdat, 1'b0);
    chk("rst_status", status, 2'b00);
    chk("rst_taken", sample_taken, 1'b0);
    pend_v = 1'b0; pend_l = '0; pend_r = '0; frm_l = '0; frm_r = '0; st_m = 2'b00;
    @(negedge CLK);
    rst = 1'b1;
  endtask

  // One bclk period (fall, then rise 4 CLK later); s is dacdat as seen at the rising edge.
  // stb raises audio_ready on the CLK where the DUT acts on this rising edge.
  task automatic bclk_period(input bit lr, input bit stb, input logic [31:0] sl,
                             input logic [31:0] sr, output logic s);
    bclk = 1'b0; daclrck = lr;
    repeat (4) @(negedge CLK);
    s = dacdat;
    bclk = 1'b1;
    if (stb) begin
      repeat (SYNC) @(negedge CLK);
      x_left = sl; x_right = sr; audio_ready = 1'b1;
      @(negedge CLK);
      audio_ready = 1'b0;
      repeat (4 - SYNC - 1) @(negedge CLK);
    end else begin
      repeat (4) @(negedge CLK);
    end
  endtask

  // The last bit of a slot is sampled on the first rising edge of the following slot.
  task automatic close_slot(input logic s);
    if (have_slot) begin
      acc = {acc[30:0], s};
      chk(slot_tag, acc, exp_w);
    end
  endtask

  task automatic run_slot(input bit lr, input int n, input logic [31:0] word, input string tag,
                          input int rst_k, input bit stb, input logic [31:0] sl,
                          input logic [31:0] sr);
    logic s;
    int   keep;
    for (int k = 0; k < n; k++) begin
      if (k == rst_k) do_reset();
      bclk_period(lr, stb && (k == 0), sl, sr, s);
      if (k == 0) begin
        close_slot(s);
        acc = '0; have_slot = 1'b1; slot_tag = tag;
        exp_w = word >> (32 - n);
        if (rst_k > 0) begin
          keep  = rst_k - 1;
          exp_w = (exp_w >> (n - keep)) << (n - keep);
        end
      end else begin
        acc = {acc[30:0], s};
      end
    end
  endtask

  task automatic run_frame(input string tag, input int nl, input int rst_r, input bit coll,
                           input logic [31:0] cl, input logic [31:0] cr);
    int          t0;
    logic [31:0] exp_t, wl, wr;
    exp_t = 0;
    if (en) begin
      if (pend_v) begin
        frm_l = pend_l; frm_r = pend_r; pend_v = 1'b0; exp_t = 1;
      end else begin
        st_m[0] = 1'b1;
      end
    end
    if (coll) begin
      pend_l = cl; pend_r = cr; pend_v = 1'b1;
    end
    wl = en ? frm_l : 32'h0;
    wr = en ? frm_r : 32'h0;
    t0 = taken_cnt;
    run_slot(1'b0, nl, wl, {tag, "_L"}, -1, coll, cl, cr);
    run_slot(1'b1, 32, wr, {tag, "_R"}, rst_r, 1'b0, 32'h0, 32'h0);
    chk({tag, "_taken"}, taken_cnt - t0, exp_t);
    chk({tag, "_status"}, status, st_m);
  endtask

  initial begin
    logic        s;
    logic [31:0] a, b;
    int          nstb;
    bit          coll;

    repeat (3) @(negedge CLK);
    rst = 1'b1;
    @(negedge CLK);
    chk("init_status", status, 2'b00);
    chk("init_dacdat", dacdat, 1'b0);

    strobe(32'h8000_0001, 32'h7FFF_FFFE);
    run_frame("frame", 32, -1, 1'b0, 32'h0, 32'h0);

    run_frame("underrun1", 32, -1, 1'b0, 32'h0, 32'h0);
    run_frame("underrun2", 32, -1, 1'b0, 32'h0, 32'h0);
    clr();

    strobe(32'h1234_5678, 32'h9ABC_DEF0);
    strobe(32'hCAFE_F00D, 32'h0BAD_BEEF);
    chk("overrun_flag", status, st_m);
    run_frame("overrun", 32, -1, 1'b0, 32'h0, 32'h0);
    clr();

    strobe(32'h0F0F_0F0F, 32'hF0F0_F0F0);
    run_frame("collide", 32, -1, 1'b1, 32'h5555_AAAA, 32'hAAAA_5555);
    run_frame("collide_next", 32, -1, 1'b0, 32'h0, 32'h0);

    en = 1'b0;
    strobe(32'h1357_9BDF, 32'h2468_ACE0);
    run_frame("en0", 32, -1, 1'b0, 32'h0, 32'h0);
    en = 1'b1;
    run_frame("en1", 32, -1, 1'b0, 32'h0, 32'h0);

    strobe(32'hDEAD_BEEF, 32'hC001_D00D);
    run_frame("short", 16, -1, 1'b0, 32'h0, 32'h0);

    run_frame("pre_rst", 32, -1, 1'b0, 32'h0, 32'h0);
    strobe(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_frame("rst", 32, 10, 1'b0, 32'h0, 32'h0);
    run_frame("post_rst", 32, -1, 1'b0, 32'h0, 32'h0);
    strobe(32'h7654_3210, 32'h89AB_CDEF);
    run_frame("resume", 32, -1, 1'b0, 32'h0, 32'h0);

    for (int it = 0; it < 12; it++) begin
      en   = ($urandom_range(0, 3) != 0);
      nstb = $urandom_range(0, 2);
      for (int j = 0; j < nstb; j++) begin
        a = $urandom; b = $urandom;
        strobe(a, b);
      end
      if ($urandom_range(0, 3) == 0) clr();
      coll = ($urandom_range(0, 3) == 0);
      a = $urandom; b = $urandom;
      run_frame($sformatf("rnd%0d", it), 32, -1, coll, a, b);
    end

    bclk_period(1'b0, 1'b0, 32'h0, 32'h0, s);
    close_slot(s);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
